// File: rtl/key_cmd_sched.sv
// Key command scheduler: one-shot key events plus hold-to-repeat, queued in a small FIFO.
// Optional KEY_CMD_DROP_CNT_EN adds a saturating drop_cnt output.
module key_cmd_sched #(
    parameter int unsigned      CNT_W       = 20,
    parameter logic [CNT_W-1:0] DAS_DELAY   = 20'd300000,
    parameter logic [CNT_W-1:0] ARR_PERIOD  = 20'd50000,
    parameter logic [12:0]      REPEAT_MASK = 13'h000F,
    parameter int unsigned      FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keycode,
    input  logic       keystrobe,
    input  logic       key_held,
    input  logic       cmd_ready,
    input  logic       ovf_clr,
    output logic       cmd_valid,
    output logic [3:0] cmd_code,
    output logic       cmd_repeat,
    output logic       overflow
`ifdef KEY_CMD_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    localparam int unsigned      AW       = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DAS_LAST = DAS_DELAY - CNT_ONE;
    localparam logic [CNT_W-1:0] ARR_LAST = ARR_PERIOD - CNT_ONE;
    localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [15:0]      MASK16   = {3'b000, REPEAT_MASK};

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       lat_q;

    logic       strobe_ok;
    logic       push;
    logic [4:0] push_data;

    // Codes 13..15 (including the multi-key code) are not commands.
    assign strobe_ok = keystrobe && (keycode <= 4'd12);

    // A fresh press always wins over release and over a repeat due this cycle.
    always_comb begin
        push      = 1'b0;
        push_data = 5'd0;
        if (strobe_ok) begin
            push      = 1'b1;
            push_data = {keycode, 1'b0};
        end else begin
            case (state_q)
                StDelay: begin
                    if (key_held && (cnt_q == DAS_LAST)) begin
                        push      = 1'b1;
                        push_data = {lat_q, 1'b1};
                    end
                end
                StRepeat: begin
                    if (key_held && (cnt_q == ARR_LAST)) begin
                        push      = 1'b1;
                        push_data = {lat_q, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lat_q   <= 4'd0;
        end else if (strobe_ok) begin
            cnt_q <= '0;
            if (MASK16[keycode] && key_held) begin
                state_q <= StDelay;
                lat_q   <= keycode;
            end else begin
                state_q <= StIdle;
            end
        end else begin
            case (state_q)
                StDelay: begin
                    if (!key_held) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == DAS_LAST) begin
                        state_q <= StRepeat;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                StRepeat: begin
                    if (!key_held) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == ARR_LAST) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    logic [4:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q, wr_d, rd_d;
    logic        full, pop, push_ok, drop;
    logic [4:0]  head_d;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = cmd_valid && cmd_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign wr_d    = push_ok ? (wr_q + PTR_ONE) : wr_q;
    assign rd_d    = pop ? (rd_q + PTR_ONE) : rd_q;

    // Next head: the entry being written this cycle is not in mem_q yet.
    always_comb begin
        head_d = 5'd0;
        if (wr_d != rd_d) begin
            if (push_ok && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 4'd0;
            cmd_repeat <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cmd_valid  <= (wr_d != rd_d);
            cmd_code   <= head_d[4:1];
            cmd_repeat <= head_d[0];
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef KEY_CMD_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (ovf_clr) begin
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_key_cmd_sched.sv
// Bench for key_cmd_sched: vector table, directed corner sequences and a randomized run
// checked against a time-based behavioural model.
module tb_key_cmd_sched;

    localparam int DAS   = 4;
    localparam int ARR   = 2;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [3:0] keycode;
    logic       keystrobe;
    logic       key_held;
    logic       cmd_ready;
    logic       ovf_clr;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       cmd_repeat;
    logic       overflow;
`ifdef KEY_CMD_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    key_cmd_sched #(
        .CNT_W      (20),
        .DAS_DELAY  (20'd4),
        .ARR_PERIOD (20'd2),
        .REPEAT_MASK(13'h000F),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keycode   (keycode),
        .keystrobe (keystrobe),
        .key_held  (key_held),
        .cmd_ready (cmd_ready),
        .ovf_clr   (ovf_clr),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_repeat(cmd_repeat),
        .overflow  (overflow)
`ifdef KEY_CMD_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue plus an absolute "next repeat due" time.
    logic [4:0]  mq[$];
    bit          m_armed;
    int          m_due;
    logic [3:0]  m_lat;
    bit          m_ovf;
    int          m_drop;
    int          tnow = 0;
    logic [15:0] m_mask = 16'h000F;

    task automatic model_step();
        bit         mpop, mpush;
        logic [4:0] pd;
        if (rst) begin
            mq.delete();
            m_armed = 0;
            m_ovf   = 0;
            m_drop  = 0;
        end else begin
            mpop  = (mq.size() > 0) && cmd_ready;
            mpush = 0;
            pd    = 5'd0;
            if (keystrobe && keycode <= 4'd12) begin
                mpush   = 1;
                pd      = {keycode, 1'b0};
                m_armed = m_mask[keycode] && key_held;
                m_lat   = keycode;
                m_due   = tnow + DAS;
            end else if (m_armed) begin
                if (!key_held) begin
                    m_armed = 0;
                end else if (tnow == m_due) begin
                    mpush = 1;
                    pd    = {m_lat, 1'b1};
                    m_due = tnow + ARR;
                end
            end
            if (mpop) void'(mq.pop_front());
            if (ovf_clr) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            if (mpush) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(pd);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        tnow++;
    endtask

    task automatic do_reset();
        rst = 1'b1; keystrobe = 1'b0; keycode = 4'd0; key_held = 1'b0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [3:0] c, input logic r);
        chk({nm, "_valid"}, 32'(cmd_valid), 32'(v));
        chk({nm, "_code"}, 32'(cmd_code), 32'(c));
        chk({nm, "_rep"}, 32'(cmd_repeat), 32'(r));
    endtask

    typedef struct {
        logic       ks;
        logic [3:0] kc;
        logic       held;
        logic       rdy;
        logic       v;
        logic [3:0] c;
        logic       r;
    } vec_t;

    vec_t tbl[12];
    int   seen;
    logic [3:0] exp_codes[3];
    bit   busy;
    logic held_lvl;

    initial begin
        // Repeat timing: press code 2 at t=0, held through t=9, consumer always ready.
        tbl[0]  = '{1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0};
        tbl[1]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[3]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[4]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1};
        tbl[5]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[6]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1};
        tbl[7]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1};
        tbl[9]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[11] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};

        do_reset();
        chk_out("reset", 1'b0, 4'd0, 1'b0);
        chk("reset_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 12; i++) begin
            keystrobe = tbl[i].ks; keycode = tbl[i].kc;
            key_held = tbl[i].held; cmd_ready = tbl[i].rdy;
            tick();
            chk_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].c, tbl[i].r);
        end

        // Non-repeat key held long: exactly one command.
        do_reset();
        cmd_ready = 1'b1; keystrobe = 1'b1; keycode = 4'd5; key_held = 1'b1;
        tick();
        chk_out("norep_first", 1'b1, 4'd5, 1'b0);
        keystrobe = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_valid) seen++;
        end
        chk("norep_extra", 32'(seen), 32'd0);
        key_held = 1'b0;

        // Overflow with a stalled consumer.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            keystrobe = 1'b1; keycode = 4'(7 + k); key_held = 1'b1;
            tick();
            chk($sformatf("ovf_after_%0d", 7 + k), 32'(overflow), 32'(k == 4));
            keystrobe = 1'b0; key_held = 1'b0;
            tick();
        end
        chk_out("full_head", 1'b1, 4'd7, 1'b0);
`ifdef KEY_CMD_DROP_CNT_EN
        chk("drop_cnt_one", 32'(drop_cnt), 32'd1);
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
`ifdef KEY_CMD_DROP_CNT_EN
        chk("drop_cnt_clr", 32'(drop_cnt), 32'd0);
`endif
        // Drop coinciding with ovf_clr: set wins.
        keystrobe = 1'b1; keycode = 4'd11; ovf_clr = 1'b1;
        tick();
        keystrobe = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
`ifdef KEY_CMD_DROP_CNT_EN
        chk("drop_cnt_set_wins", 32'(drop_cnt), 32'd1);
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared2", 32'(overflow), 32'd0);

        // Full queue: pop and push in the same cycle.
        keystrobe = 1'b1; keycode = 4'd12; cmd_ready = 1'b1;
        tick();
        keystrobe = 1'b0;
        chk_out("pushpop", 1'b1, 4'd8, 1'b0);
        chk("pushpop_ovf", 32'(overflow), 32'd0);
        exp_codes[0] = 4'd9; exp_codes[1] = 4'd10; exp_codes[2] = 4'd12;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk_out($sformatf("drain%0d", j), 1'b1, exp_codes[j], 1'b0);
        end
        tick();
        chk_out("drained", 1'b0, 4'd0, 1'b0);

        // Codes 15 and 13 are ignored; no repeat follows.
        do_reset();
        keystrobe = 1'b1; keycode = 4'hF; key_held = 1'b1;
        tick();
        chk("inv_f_valid", 32'(cmd_valid), 32'd0);
        keycode = 4'd13;
        tick();
        keystrobe = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cmd_valid) seen++;
        end
        chk("inv_no_cmd", 32'(seen + (cmd_valid ? 1 : 0)), 32'd0);

        // Reset in REPEAT with three queued entries.
        do_reset();
        keystrobe = 1'b1; keycode = 4'd1; key_held = 1'b1;
        tick();
        keystrobe = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_out("rep3_head", 1'b1, 4'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("midrst", 1'b0, 4'd0, 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_valid) seen++;
        end
        chk("midrst_norep", 32'(seen), 32'd0);
        key_held = 1'b0;

        // Randomized run against the model.
        do_reset();
        busy = 0;
        held_lvl = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) busy = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) held_lvl = ~held_lvl;
            keycode = 4'($urandom_range(0, 15));
            keystrobe = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                keystrobe = 1'b1;
                if ($urandom_range(0, 1) == 1) keycode = 4'($urandom_range(0, 3));
                if ($urandom_range(0, 4) != 0) held_lvl = 1'b1;
            end
            key_held  = held_lvl;
            cmd_ready = busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 699) == 0);
            tick();
            chk("rnd_valid", 32'(cmd_valid), 32'(mq.size() > 0));
            chk("rnd_code", 32'(cmd_code), (mq.size() > 0) ? 32'(mq[0][4:1]) : 32'd0);
            chk("rnd_rep", 32'(cmd_repeat), (mq.size() > 0) ? 32'(mq[0][0]) : 32'd0);
            chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
`ifdef KEY_CMD_DROP_CNT_EN
            chk("rnd_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
